hit_judge: RTL and testbench

- Parametrised successor to the single-bit hit detector: judges player button presses against N mole-up signals during a game.
- Adds rising-edge press detection, per-mole turnoff pulses, saturating hit/miss/streak counters, and a miss-penalty lockout.
- Sits between the button inputs, the display controller (mole1..N levels, game flag) and the score/HEX display path.

---
 rtl/hit_judge.sv | 133 +++++++++++++
 tb/tb_hit_judge.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/hit_judge.sv
// Whack-a-mole press judge: edge-detects N buttons, scores hits/misses against
// mole-up levels, tracks streaks, and enforces a lockout penalty after any miss.
module hit_judge #(
  parameter int NUM_MOLES      = 3,
  parameter int SCORE_W        = 8,
  parameter int LOCKOUT_CYCLES = 25000000,
  parameter int LOCK_W         = 25
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 game,
  input  logic [NUM_MOLES-1:0] button,
  input  logic [NUM_MOLES-1:0] mole,
  output logic [NUM_MOLES-1:0] turnoff,
  output logic [SCORE_W-1:0]   score,
  output logic [SCORE_W-1:0]   misses,
  output logic [SCORE_W-1:0]   streak,
  output logic [SCORE_W-1:0]   best_streak,
  output logic                 locked
);

  localparam int PC_W  = $clog2(NUM_MOLES + 1);
  localparam int SUM_W = ((SCORE_W > PC_W) ? SCORE_W : PC_W) + 1;
  localparam logic [SCORE_W-1:0] MAX_CNT   = '1;
  localparam logic [LOCK_W-1:0]  LOCK_LOAD = LOCK_W'(LOCKOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, PLAY, LOCK} state_t;

  function automatic logic [PC_W-1:0] popcount(input logic [NUM_MOLES-1:0] v);
    logic [PC_W-1:0] c;
    c = '0;
    for (int i = 0; i < NUM_MOLES; i++) c = c + PC_W'(v[i]);
    return c;
  endfunction

  function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                 input logic [PC_W-1:0]    b);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(b);
    if (s > SUM_W'(MAX_CNT)) return MAX_CNT;
    return s[SCORE_W-1:0];
  endfunction

  state_t               state, state_nxt;
  logic [LOCK_W-1:0]    cnt, cnt_nxt;
  logic [NUM_MOLES-1:0] btn_q;
  logic [NUM_MOLES-1:0] press, hit_vec, miss_vec;
  logic [PC_W-1:0]      hit_cnt, miss_cnt;
  logic [NUM_MOLES-1:0] turnoff_nxt;
  logic [SCORE_W-1:0]   score_nxt, misses_nxt, streak_nxt, best_nxt;

  assign press    = button & ~btn_q;
  assign hit_vec  = press & mole;
  assign miss_vec = press & ~mole;
  assign hit_cnt  = popcount(hit_vec);
  assign miss_cnt = popcount(miss_vec);
  assign locked   = (state == LOCK);

  // Stage p0: next-state and counter update
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    turnoff_nxt = '0;
    score_nxt   = score;
    misses_nxt  = misses;
    streak_nxt  = streak;
    best_nxt    = best_streak;
    case (state)
      IDLE: begin
        if (game) begin
          state_nxt  = PLAY;
          score_nxt  = '0;
          misses_nxt = '0;
          streak_nxt = '0;
          best_nxt   = '0;
        end
      end
      PLAY: begin
        if (!game) begin
          state_nxt = IDLE;
        end else begin
          turnoff_nxt = hit_vec;
          score_nxt   = sat_add(score, hit_cnt);
          misses_nxt  = sat_add(misses, miss_cnt);
          if (|miss_vec) begin
            streak_nxt = '0;
            state_nxt  = LOCK;
            cnt_nxt    = LOCK_LOAD;
          end else begin
            streak_nxt = sat_add(streak, hit_cnt);
          end
          if (streak_nxt > best_streak) best_nxt = streak_nxt;
        end
      end
      LOCK: begin
        // LOCK spans LOCKOUT_CYCLES cycles: counts LOCKOUT_CYCLES-1 down to 0
        if (!game) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (cnt == '0) begin
          state_nxt = PLAY;
        end else begin
          cnt_nxt = cnt - LOCK_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p1: registered state, pulses and counters
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      btn_q       <= '0;
      turnoff     <= '0;
      score       <= '0;
      misses      <= '0;
      streak      <= '0;
      best_streak <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      btn_q       <= button;
      turnoff     <= turnoff_nxt;
      score       <= score_nxt;
      misses      <= misses_nxt;
      streak      <= streak_nxt;
      best_streak <= best_nxt;
    end
  end

endmodule

// File: tb/tb_hit_judge.sv
// Directed bench for hit_judge: hits, misses with lockout, mixed presses,
// saturation, round restart and asynchronous reset mid-lockout.
module tb_hit_judge;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       game  = 1'b0;
  logic [2:0] button = '0;
  logic [2:0] mole   = '0;
  logic [2:0] turnoff;
  logic [2:0] score, misses, streak, best_streak;
  logic       locked;

  int checks = 0;
  int errors = 0;

  hit_judge #(
    .NUM_MOLES(3), .SCORE_W(3), .LOCKOUT_CYCLES(4), .LOCK_W(3)
  ) dut (
    .clock(clock), .reset(reset), .game(game), .button(button), .mole(mole),
    .turnoff(turnoff), .score(score), .misses(misses), .streak(streak),
    .best_streak(best_streak), .locked(locked)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [2:0] t, input logic [2:0] s,
                         input logic [2:0] m, input logic [2:0] st, input logic [2:0] b,
                         input logic l);
    chk({tag, ".turnoff"}, 16'(turnoff), 16'(t));
    chk({tag, ".score"}, 16'(score), 16'(s));
    chk({tag, ".misses"}, 16'(misses), 16'(m));
    chk({tag, ".streak"}, 16'(streak), 16'(st));
    chk({tag, ".best"}, 16'(best_streak), 16'(b));
    chk({tag, ".locked"}, 16'(locked), 16'(l));
  endtask

  initial begin
    #2;
    chk_all("reset", 3'b000, 0, 0, 0, 0, 1'b0);
    tick();
    reset = 1'b0;

    // Start round
    game = 1'b1;
    tick();
    chk_all("start", 3'b000, 0, 0, 0, 0, 1'b0);

    // Hit with held button
    mole = 3'b010; button = 3'b010;
    tick();
    chk_all("hit1", 3'b010, 1, 0, 1, 1, 1'b0);
    tick();
    chk_all("hold1", 3'b000, 1, 0, 1, 1, 1'b0);
    tick(); tick(); tick();
    chk_all("hold4", 3'b000, 1, 0, 1, 1, 1'b0);
    button = 3'b000;
    tick();

    // Miss enters lockout
    mole = 3'b001; button = 3'b100;
    tick();
    chk_all("miss", 3'b000, 1, 1, 0, 1, 1'b1);
    button = 3'b001;
    tick();
    chk_all("lockpress", 3'b000, 1, 1, 0, 1, 1'b1);
    button = 3'b000;
    tick();
    chk("lock3.locked", 16'(locked), 16'd1);
    tick();
    chk("lock4.locked", 16'(locked), 16'd1);
    tick();
    chk("unlock.locked", 16'(locked), 16'd0);
    button = 3'b001;
    tick();
    chk_all("posthit", 3'b001, 2, 1, 1, 1, 1'b0);
    button = 3'b000;
    tick();
    mole = 3'b010; button = 3'b010;
    tick();
    chk_all("hit3", 3'b010, 3, 1, 2, 2, 1'b0);
    button = 3'b000;
    tick();

    // Mixed simultaneous hits and a miss
    mole = 3'b011; button = 3'b111;
    tick();
    chk_all("mixed", 3'b011, 5, 2, 0, 2, 1'b1);
    button = 3'b000;
    tick(); tick(); tick();
    chk("mixlock.locked", 16'(locked), 16'd1);
    tick();
    chk("mixunlock.locked", 16'(locked), 16'd0);

    // Game over holds values, restart clears them
    game = 1'b0;
    tick();
    chk_all("idle", 3'b000, 5, 2, 0, 2, 1'b0);
    mole = 3'b001; button = 3'b001;
    tick();
    chk_all("idlepress", 3'b000, 5, 2, 0, 2, 1'b0);
    button = 3'b000;
    tick();
    game = 1'b1;
    tick();
    chk_all("restart", 3'b000, 0, 0, 0, 0, 1'b0);

    // Saturation at 7 over 9 hits
    for (int k = 1; k <= 9; k++) begin
      button = 3'b001;
      tick();
      chk("sat.score", 16'(score), 16'((k < 7) ? k : 7));
      chk("sat.turnoff", 16'(turnoff), 16'(3'b001));
      button = 3'b000;
      tick();
    end
    chk_all("sat", 3'b000, 7, 0, 7, 7, 1'b0);

    // Async reset in the middle of a lockout
    mole = 3'b000; button = 3'b010;
    tick();
    chk_all("miss2", 3'b000, 7, 1, 0, 7, 1'b1);
    button = 3'b000;
    tick();
    #3 reset = 1'b1;
    #1;
    chk_all("asyncrst", 3'b000, 0, 0, 0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
